// File: rtl/debug_cmd_dispatch.sv
// JTAG debug command dispatcher: brings update-IR/update-DR toggles into clk and queues {ir, sr} commands.
// Optional feature DEBUG_CMD_PARITY_EN drops odd-parity sr words and flags them on parity_err.
module debug_cmd_dispatch #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [DATA_W-1:0]      sr,
  input  logic                   uir_tgl,
  input  logic                   udr_tgl,
  input  logic                   cmd_ready,
  input  logic                   ovf_clr,
  output logic                   cmd_valid,
  output logic [DATA_W-1:0]      jdo,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
`ifdef DEBUG_CMD_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DATA_W;

  logic uir_s1_r, uir_s2_r, uir_h_r;
  logic udr_s1_r, udr_s2_r, udr_h_r;
  logic uir_evt_s, udr_evt_s;
  logic [IR_W-1:0]  ir_reg_r;
  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             overflow_r;
  logic             push_req_s, push_s, pop_s, full_s, drop_s;
  logic [ENT_W-1:0] head_s;
  logic [IR_W-1:0]  head_ir_s;

`ifdef DEBUG_CMD_PARITY_EN
  logic par_bad_s;
  logic parity_err_r;

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Toggle synchronizers; reset preloads every stage with the live level so release creates no event
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_s1_r <= uir_tgl;
      uir_s2_r <= uir_tgl;
      uir_h_r  <= uir_tgl;
      udr_s1_r <= udr_tgl;
      udr_s2_r <= udr_tgl;
      udr_h_r  <= udr_tgl;
    end else begin
      uir_s1_r <= uir_tgl;
      uir_s2_r <= uir_s1_r;
      uir_h_r  <= uir_s2_r;
      udr_s1_r <= udr_tgl;
      udr_s2_r <= udr_s1_r;
      udr_h_r  <= udr_s2_r;
    end
  end

  assign uir_evt_s = uir_s2_r ^ uir_h_r;
  assign udr_evt_s = udr_s2_r ^ udr_h_r;

  // Instruction capture; a same-cycle push still sees the old value
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg_r <= {IR_W{1'b0}};
    end else if (uir_evt_s) begin
      ir_reg_r <= ir_in;
    end else begin
      ir_reg_r <= ir_reg_r;
    end
  end

`ifdef DEBUG_CMD_PARITY_EN
  assign par_bad_s  = udr_evt_s & odd_parity(sr);
  assign push_req_s = udr_evt_s & ~odd_parity(sr);
`else
  assign push_req_s = udr_evt_s;
`endif

  assign cmd_valid = (level_r != {LVL_W{1'b0}});
  assign full_s    = (level_r == LVL_W'(DEPTH));
  assign pop_s     = cmd_valid & cmd_ready & ~reset;
  assign push_s    = push_req_s & (~full_s | pop_s);
  assign drop_s    = push_req_s & full_s & ~pop_s;

  // Command storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ir_reg_r, sr};
    end
  end

  // Queue pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        level_r <= level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
        level_r <= level_r - LVL_W'(1);
      end else begin
        level_r <= level_r;
      end
    end
  end

  // Sticky drop flag; a drop beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef DEBUG_CMD_PARITY_EN
  // Sticky parity flag, cleared together with overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_r <= 1'b0;
    end else if (par_bad_s) begin
      parity_err_r <= 1'b1;
    end else if (ovf_clr) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= parity_err_r;
    end
  end

  assign parity_err = parity_err_r;
`endif

  assign head_s    = mem_r[rd_ptr_r];
  assign head_ir_s = head_s[ENT_W-1:DATA_W];
  assign jdo       = cmd_valid ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
  assign overflow  = overflow_r;
  assign level     = level_r;

  // One-hot channel strobes, live only in the pop cycle
  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop_s) begin
      if (jdo[DATA_W-1]) begin
        take_action[head_ir_s] = 1'b1;
      end else begin
        take_no_action[head_ir_s] = 1'b1;
      end
    end else begin
      take_action    = '0;
      take_no_action = '0;
    end
  end

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Self-checking bench for debug_cmd_dispatch: directed scenarios plus random ops against a queue model.
module tb_debug_cmd_dispatch;
  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int DEPTH  = 4;
  localparam int CH_N   = 4;

  typedef logic [IR_W+DATA_W-1:0] ent_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [IR_W-1:0]     ir_in;
  logic [DATA_W-1:0]   sr_in;
  logic                uir_tgl, udr_tgl, cmd_ready, ovf_clr;
  logic                cmd_valid, overflow;
  logic [DATA_W-1:0]   jdo;
  logic [CH_N-1:0]     take_action, take_no_action;
  logic [2:0]          level;
`ifdef DEBUG_CMD_PARITY_EN
  logic                parity_err;
`endif

  int checks = 0;
  int errors = 0;

  ent_t            q[$];
  logic [IR_W-1:0] m_ir;
  logic            m_ovf;
  logic            m_perr;

  debug_cmd_dispatch #(.DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr_in),
    .uir_tgl(uir_tgl), .udr_tgl(udr_tgl), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .overflow(overflow), .level(level)
`ifdef DEBUG_CMD_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [CH_N-1:0]   ea, en;
    logic [DATA_W-1:0] ej;
    logic [IR_W-1:0]   hir;
    ent_t              h;
    ea = '0;
    en = '0;
    ej = '0;
    if (q.size() > 0) begin
      h   = q[0];
      ej  = h[DATA_W-1:0];
      hir = h[IR_W+DATA_W-1:DATA_W];
      if (cmd_ready && !reset) begin
        if (ej[DATA_W-1]) ea[hir] = 1'b1;
        else              en[hir] = 1'b1;
      end
    end
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".valid"}, 64'(cmd_valid), 64'(q.size() != 0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".jdo"}, 64'(jdo), 64'(ej));
    chk({tag, ".act"}, 64'(take_action), 64'(ea));
    chk({tag, ".noact"}, 64'(take_no_action), 64'(en));
`ifdef DEBUG_CMD_PARITY_EN
    chk({tag, ".perr"}, 64'(parity_err), 64'(m_perr));
`endif
  endtask

  // One transaction: optional uir and/or udr toggle, landing 3 edges later with given ready/clear
  task automatic step(input logic do_uir, input logic [IR_W-1:0] ir_v,
                      input logic do_udr, input logic [DATA_W-1:0] sr_v,
                      input logic rdy, input logic clr);
    logic popped, full, ok, dropped;
    if (do_uir) begin ir_in = ir_v; uir_tgl = ~uir_tgl; end
    if (do_udr) begin sr_in = sr_v; udr_tgl = ~udr_tgl; end
    tick();
    tick();
    cmd_ready = rdy;
    ovf_clr   = clr;
    #1;
    check_state("pre_land");
    tick();
    popped  = rdy && (q.size() > 0);
    full    = (q.size() == DEPTH);
    ok      = do_udr;
`ifdef DEBUG_CMD_PARITY_EN
    if (do_udr && (^sr_v)) begin ok = 1'b0; m_perr = 1'b1; end
    else if (clr) m_perr = 1'b0;
`endif
    dropped = ok && full && !popped;
    if (popped) void'(q.pop_front());
    if (ok && !dropped) q.push_back({m_ir, sr_v});
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (do_uir) m_ir = ir_v;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    check_state("post_land");
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    #1;
    check_state("pop");
    tick();
    if (q.size() > 0) void'(q.pop_front());
    cmd_ready = 1'b0;
    #1;
    check_state("after_pop");
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    tick();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check_state("clr");
  endtask

  function automatic logic [DATA_W-1:0] rnd_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  initial begin
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] saved [5];
    reset = 1'b1; ir_in = '0; sr_in = '0; uir_tgl = 1'b0; udr_tgl = 1'b0;
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    m_ir = '0; m_ovf = 1'b0; m_perr = 1'b0;
    repeat (3) tick();
    check_state("in_reset");
    reset = 1'b0;
    repeat (4) tick();
    check_state("after_reset");

    // Basic action command on channel 2
    step(1'b1, 2'd2, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 38'h20_0000_0001, 1'b1, 1'b0);
    cmd_ready = 1'b1;
    #1;
    chk("basic.act", 64'(take_action), 64'(4'b0100));
    chk("basic.jdo", 64'(jdo), 64'(38'h20_0000_0001));
    pop_one();

    // Overflow: five pushes with no consumer
    for (int i = 0; i < 5; i++) begin
      saved[i] = rnd_sr();
      step(1'b0, '0, 1'b1, saved[i], 1'b0, 1'b0);
    end
    chk("ovf.level", 64'(level), 64'(4));
    chk("ovf.flag", 64'(overflow), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("ovf.order", 64'(jdo), 64'(saved[i]));
      pop_one();
    end
    clr_pulse();

    // Full queue with push and pop in the same cycle
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, rnd_sr(), 1'b0, 1'b0);
    v = rnd_sr();
    step(1'b0, '0, 1'b1, v, 1'b1, 1'b0);
    chk("full_pp.level", 64'(level), 64'(4));
    chk("full_pp.ovf", 64'(overflow), 64'(0));
    // Drop coinciding with clear leaves overflow set
    step(1'b0, '0, 1'b1, rnd_sr(), 1'b0, 1'b1);
    chk("setwins.ovf", 64'(overflow), 64'(1));
    for (int i = 0; i < 3; i++) pop_one();
    chk("full_pp.last", 64'(jdo), 64'(v));
    pop_one();
    clr_pulse();

    // Same-cycle uir and udr: entry keeps the old ir
    step(1'b1, 2'd1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 38'h00_1234_5678, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 38'h00_0000_0003, 1'b0, 1'b0);
    cmd_ready = 1'b1;
    #1;
    chk("same.noact1", 64'(take_no_action), 64'(4'b0010));
    pop_one();
    cmd_ready = 1'b1;
    #1;
    chk("same.noact2", 64'(take_no_action), 64'(4'b1000));
    pop_one();

`ifdef DEBUG_CMD_PARITY_EN
    step(1'b0, '0, 1'b1, 38'h00_0000_0001, 1'b0, 1'b0);
    chk("par.err", 64'(parity_err), 64'(1));
    chk("par.level", 64'(level), 64'(0));
    clr_pulse();
    chk("par.clr", 64'(parity_err), 64'(0));
`endif

    // Random operations against the queue model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: step(1'b1, IR_W'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);
        1, 2: step(1'b0, '0, 1'b1, rnd_sr(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0));
        default: begin
          if (q.size() > 0) pop_one();
          else step(1'b1, IR_W'($urandom_range(0, 3)), 1'b1, rnd_sr(), 1'b0, 1'b0);
        end
      endcase
    end

    // Reset mid-operation with three entries queued and a udr event during reset
    while (q.size() > 0) pop_one();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, rnd_sr(), 1'b0, 1'b0);
    chk("rst.pre", 64'(level), 64'(3));
    reset = 1'b1;
    udr_tgl = ~udr_tgl;
    tick();
    q.delete();
    m_ovf = 1'b0; m_ir = '0; m_perr = 1'b0;
    check_state("rst.mid");
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check_state("rst.nospur");
    step(1'b0, '0, 1'b1, 38'h20_0000_0000, 1'b1, 1'b0);
    cmd_ready = 1'b1;
    #1;
    chk("rst.ch0", 64'(take_action), 64'(4'b0001));
    pop_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
